hack_cpu: RTL and testbench

- Hack (nand2tetris) 16-bit CPU core. Single-cycle: executes one instruction per clk.
- Fetches `instruction` from the program memory at `pc`.
- Reads data memory via `inM`; writes data memory via `outM`/`writeM`.
- Sits in the top level between the boot ROM / external SRAM instruction path and the memory-mapped RAM/IO data bus.

---
 rtl/hack_pkg.sv | 52 +++++
 rtl/hack_alu.sv | 44 ++++
 rtl/hack_cpu.sv | 97 +++++++++
 tb/tb_hack_cpu.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack 16-bit CPU core.
// Holds the instruction field positions, the dest/jump bit masks, the ALU
// control struct and the jump condition decode shared by hack_cpu.
package hack_pkg;

  localparam int XLEN = 16;

  // Instruction field bit positions
  localparam int C_BIT   = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  // Destination masks within the 3-bit dest field
  localparam logic [2:0] DEST_A = 3'b100;
  localparam logic [2:0] DEST_D = 3'b010;
  localparam logic [2:0] DEST_M = 3'b001;

  // Jump masks within the 3-bit jump field
  localparam logic [2:0] JLT = 3'b100;
  localparam logic [2:0] JEQ = 3'b010;
  localparam logic [2:0] JGT = 3'b001;

  // ALU control bits in instruction order (zx is the MSB, bit 11)
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } comp_t;

  // Evaluate the jump field against the ALU status flags.
  // "Greater than" means neither negative nor zero.
  function automatic logic jump_taken(input logic [2:0] jump,
                                      input logic       zr,
                                      input logic       ng);
    logic lt;
    logic eq;
    logic gt;
    lt = |(jump & JLT) & ng;
    eq = |(jump & JEQ) & zr;
    gt = |(jump & JGT) & ~ng & ~zr;
    return lt | eq | gt;
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: purely combinational 16-bit datapath.
// Ports:
//   x, y         operands (x is D, y is A or M)
//   zx, nx       zero / invert x
//   zy, ny       zero / invert y
//   f            1 = add (wraps mod 2^16), 0 = bitwise and
//   no           invert the result
//   out          result
//   zr, ng       status: result is zero / result is negative (bit 15)
module hack_alu
  import hack_pkg::*;
(
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic            zx,
  input  logic            nx,
  input  logic            zy,
  input  logic            ny,
  input  logic            f,
  input  logic            no,
  output logic [XLEN-1:0] out,
  output logic            zr,
  output logic            ng
);

  logic [XLEN-1:0] x_z;
  logic [XLEN-1:0] x_n;
  logic [XLEN-1:0] y_z;
  logic [XLEN-1:0] y_n;
  logic [XLEN-1:0] fn;

  always_comb begin
    // Zeroing is applied before inversion, so zx&nx yields all ones.
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    fn  = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~fn : fn;
    zr  = (out == '0);
    ng  = out[XLEN-1];
  end

endmodule

// File: rtl/hack_cpu.sv
// Hack (nand2tetris) single-cycle CPU core. One instruction per clk.
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset (A=0, D=0, PC=RESET_PC)
//   instruction  instruction word at pc, combinational in the same cycle
//   inM          data memory read value at addressMR, same cycle
//   outM         ALU result to be written to data memory
//   writeM       data memory write strobe (held low in reset)
//   addressMR    data memory read address (current A)
//   addressMW    data memory write address (A before this cycle's update)
//   pc           address of the current instruction
module hack_cpu
  import hack_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] inM,
  output logic [XLEN-1:0] outM,
  output logic            writeM,
  output logic [XLEN-1:0] addressMR,
  output logic [XLEN-1:0] addressMW,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] d_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;

  logic            is_c;
  logic            sel_m;
  comp_t           comp;
  logic [2:0]      dest;
  logic [2:0]      jump;

  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] alu_out;
  logic            alu_zr;
  logic            alu_ng;
  logic            jmp;

  // Instruction decode; bits [14:13] carry no meaning for C-instructions.
  assign is_c  = instruction[C_BIT];
  assign sel_m = instruction[A_BIT];
  assign comp  = comp_t'(instruction[COMP_HI:COMP_LO]);
  assign dest  = instruction[DEST_HI:DEST_LO];
  assign jump  = instruction[JUMP_HI:JUMP_LO];

  assign alu_y = sel_m ? inM : a_q;

  hack_alu u_alu (
    .x   (d_q),
    .y   (alu_y),
    .zx  (comp.zx),
    .nx  (comp.nx),
    .zy  (comp.zy),
    .ny  (comp.ny),
    .f   (comp.f),
    .no  (comp.no),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // The jump target is the A value before any update by this instruction.
  assign jmp     = is_c & jump_taken(jump, alu_zr, alu_ng);
  assign pc_next = jmp ? a_q : (pc_q + 16'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= RESET_PC;
    end else begin
      if (!is_c) begin
        a_q <= instruction;
      end else if (|(dest & DEST_A)) begin
        a_q <= alu_out;
      end
      if (is_c && |(dest & DEST_D)) begin
        d_q <= alu_out;
      end
      pc_q <= pc_next;
    end
  end

  // Both addresses use the pre-update A, so AM=... writes to the old address.
  assign outM      = alu_out;
  assign writeM    = rstn & is_c & |(dest & DEST_M);
  assign addressMR = rstn ? a_q : '0;
  assign addressMW = rstn ? a_q : '0;
  assign pc        = rstn ? pc_q : RESET_PC;

endmodule

// File: tb/tb_hack_cpu.sv
// Testbench for hack_cpu: a table of per-cycle vectors (reset, instruction,
// inM and the expected combinational outputs for that cycle). Expected
// records are queued as each vector is driven and popped for comparison
// once the outputs have settled.
module tb_hack_cpu;

  logic        clk;
  logic        rstn;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] addressMR;
  logic [15:0] addressMW;
  logic [15:0] pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rstn;
    logic [15:0] instr;
    logic [15:0] in_m;
    logic [15:0] pc;
    logic        wm;
    logic [15:0] addr;
    logic [15:0] outm;
    logic        chk_out;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic        wm;
    logic [15:0] addr;
    logic [15:0] outm;
    logic        chk_out;
  } exp_t;

  localparam int NV = 36;
  vec_t vecs [NV];
  exp_t sb [$];

  hack_cpu #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressMR   (addressMR),
    .addressMW   (addressMW),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of vectors");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic [15:0] ins,
                              input logic [15:0] im, input logic [15:0] p,
                              input logic w, input logic [15:0] ad,
                              input logic [15:0] o, input logic c);
    vec_t v;
    v.rstn = r; v.instr = ins; v.in_m = im; v.pc = p;
    v.wm = w; v.addr = ad; v.outm = o; v.chk_out = c;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    // reset held: pc/writeM/address forced, D=0 visible through M=D
    vecs[0]  = mk(0, 16'hE308, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    vecs[1]  = mk(0, 16'hEA87, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    // release: pc counts 0,1,2 on A-instructions
    vecs[2]  = mk(1, 16'h0001, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[3]  = mk(1, 16'h0002, 16'h0000, 16'h0001, 0, 16'h0001, 16'h0000, 0);
    vecs[4]  = mk(1, 16'h0005, 16'h0000, 16'h0002, 0, 16'h0002, 16'h0000, 0);
    // D=A, @3, D=D+A
    vecs[5]  = mk(1, 16'hEC10, 16'h0000, 16'h0003, 0, 16'h0005, 16'h0005, 1);
    vecs[6]  = mk(1, 16'h0003, 16'h0000, 16'h0004, 0, 16'h0005, 16'h0000, 0);
    vecs[7]  = mk(1, 16'hE090, 16'h0000, 16'h0005, 0, 16'h0003, 16'h0008, 1);
    // @100, M=D, @0
    vecs[8]  = mk(1, 16'h0064, 16'h0000, 16'h0006, 0, 16'h0003, 16'h0000, 0);
    vecs[9]  = mk(1, 16'hE308, 16'h0000, 16'h0007, 1, 16'h0064, 16'h0008, 1);
    vecs[10] = mk(1, 16'h0000, 16'h0000, 16'h0008, 0, 16'h0064, 16'h0000, 0);
    // @7, D=M with inM=1234, observe D
    vecs[11] = mk(1, 16'h0007, 16'h1234, 16'h0009, 0, 16'h0000, 16'h0000, 0);
    vecs[12] = mk(1, 16'hFC10, 16'h1234, 16'h000A, 0, 16'h0007, 16'h1234, 1);
    vecs[13] = mk(1, 16'hE300, 16'h1234, 16'h000B, 0, 16'h0007, 16'h1234, 1);
    // D=0, @10, D;JEQ taken
    vecs[14] = mk(1, 16'hEA90, 16'h0000, 16'h000C, 0, 16'h0007, 16'h0000, 1);
    vecs[15] = mk(1, 16'h000A, 16'h0000, 16'h000D, 0, 16'h0007, 16'h0000, 0);
    vecs[16] = mk(1, 16'hE302, 16'h0000, 16'h000E, 0, 16'h000A, 16'h0000, 1);
    // D=1, D;JEQ not taken
    vecs[17] = mk(1, 16'hEFD0, 16'h0000, 16'h000A, 0, 16'h000A, 16'h0001, 1);
    vecs[18] = mk(1, 16'hE302, 16'h0000, 16'h000B, 0, 16'h000A, 16'h0001, 1);
    // D=0x8000 via !0x7FFF, @40, D;JLT taken
    vecs[19] = mk(1, 16'h7FFF, 16'h0000, 16'h000C, 0, 16'h000A, 16'h0000, 0);
    vecs[20] = mk(1, 16'hEC10, 16'h0000, 16'h000D, 0, 16'h7FFF, 16'h7FFF, 1);
    vecs[21] = mk(1, 16'hE350, 16'h0000, 16'h000E, 0, 16'h7FFF, 16'h8000, 1);
    vecs[22] = mk(1, 16'h0028, 16'h0000, 16'h000F, 0, 16'h7FFF, 16'h0000, 0);
    vecs[23] = mk(1, 16'hE304, 16'h0000, 16'h0010, 0, 16'h0028, 16'h8000, 1);
    // 0;JMP back to 40
    vecs[24] = mk(1, 16'hEA87, 16'h0000, 16'h0028, 0, 16'h0028, 16'h0000, 1);
    // @20, AM=M+1 with inM=5: write 6 to 20, then A=6
    vecs[25] = mk(1, 16'h0014, 16'h0005, 16'h0028, 0, 16'h0028, 16'h0000, 0);
    vecs[26] = mk(1, 16'hFDE8, 16'h0005, 16'h0029, 1, 16'h0014, 16'h0006, 1);
    // D=-1, observe D
    vecs[27] = mk(1, 16'hEE90, 16'h0000, 16'h002A, 0, 16'h0006, 16'hFFFF, 1);
    vecs[28] = mk(1, 16'hE300, 16'h0000, 16'h002B, 0, 16'h0006, 16'hFFFF, 1);
    // A=-1, 0;JMP to FFFF, A-instruction wraps pc to 0
    vecs[29] = mk(1, 16'hEEA0, 16'h0000, 16'h002C, 0, 16'h0006, 16'hFFFF, 1);
    vecs[30] = mk(1, 16'hEA87, 16'h0000, 16'h002D, 0, 16'hFFFF, 16'h0000, 1);
    vecs[31] = mk(1, 16'h0001, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 16'h0000, 0);
    vecs[32] = mk(1, 16'h0002, 16'h0000, 16'h0000, 0, 16'h0001, 16'h0000, 0);
    // reset mid-program, then restart from 0
    vecs[33] = mk(0, 16'h0003, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[34] = mk(1, 16'h0009, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[35] = mk(1, 16'h0004, 16'h0000, 16'h0001, 0, 16'h0009, 16'h0000, 0);

    rstn        = 1'b0;
    instruction = 16'h0000;
    inM         = 16'h0000;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rstn        = vecs[i].rstn;
      instruction = vecs[i].instr;
      inM         = vecs[i].in_m;
      e.pc = vecs[i].pc; e.wm = vecs[i].wm; e.addr = vecs[i].addr;
      e.outm = vecs[i].outm; e.chk_out = vecs[i].chk_out;
      sb.push_back(e);
      #1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard vec%0d actual=empty required=entry", i);
      end else begin
        e = sb.pop_front();
        chk("pc", i, pc, e.pc);
        chk("writeM", i, {15'd0, writeM}, {15'd0, e.wm});
        chk("addressMR", i, addressMR, e.addr);
        chk("addressMW", i, addressMW, e.addr);
        if (e.chk_out) chk("outM", i, outM, e.outm);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
